// File: rtl/debounce_multi.sv
// Multi-channel button/switch debouncer with per-pin polarity, one-cycle event pulses
// and per-button auto-repeat. pbtn_db[0] doubles as the system reset source.
module debounce_multi #(
  parameter int unsigned          NUM_BTNS        = 6,
  parameter int unsigned          NUM_SW          = 16,
  parameter int unsigned          CLK_FREQ_HZ     = 100000000,
  parameter int unsigned          DB_TIME_US      = 5000,
  parameter int unsigned          REPEAT_DELAY_MS = 500,
  parameter int unsigned          REPEAT_RATE_MS  = 100,
  parameter logic [NUM_BTNS-1:0]  BTN_ACTIVE_LOW  = NUM_BTNS'(1),
  parameter bit                   SIMULATE        = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] pbtn_in,
  input  logic [NUM_SW-1:0]   switch_in,
  input  logic [NUM_BTNS-1:0] repeat_en,
  output logic [NUM_BTNS-1:0] pbtn_db,
  output logic [NUM_SW-1:0]   swtch_db,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] btn_repeat,
  output logic [NUM_SW-1:0]   sw_change
);

  function automatic int unsigned min1(input longint unsigned v);
    if (v == 0) return 1;
    return 32'(v);
  endfunction

  localparam longint unsigned DbRaw  = longint'(CLK_FREQ_HZ) / 1000000 * DB_TIME_US;
  localparam longint unsigned RdRaw  = longint'(CLK_FREQ_HZ) / 1000 * REPEAT_DELAY_MS;
  localparam longint unsigned RrRaw  = longint'(CLK_FREQ_HZ) / 1000 * REPEAT_RATE_MS;

  localparam int unsigned DB_COUNT     = SIMULATE ? 4  : min1(DbRaw);
  localparam int unsigned REPEAT_DELAY = SIMULATE ? 20 : min1(RdRaw);
  localparam int unsigned REPEAT_RATE  = SIMULATE ? 8  : min1(RrRaw);

  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned DbW    = $clog2(DB_COUNT + 1);
  localparam int unsigned RcW    = $clog2(RepMax + 1);
  localparam int unsigned NumCh  = NUM_BTNS + NUM_SW;

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

  // Buttons occupy the low channels, switches the high ones.
  logic [NumCh-1:0] raw;
  logic [NumCh-1:0] sync1, sync2, stable;
  logic [DbW-1:0]   cnt [NumCh];
  logic [NumCh-1:0] done, rise, fall;

  assign raw = {switch_in, pbtn_in ^ BTN_ACTIVE_LOW};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_comb begin
    done = '0;
    for (int i = 0; i < NumCh; i++) begin
      done[i] = (sync2[i] != stable[i]) && (cnt[i] == DbW'(DB_COUNT - 1));
    end
    rise = done & sync2;
    fall = done & ~sync2;
  end

  // Any sample matching the stable level discards accumulated credit.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < NumCh; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (done[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign pbtn_db  = stable[NUM_BTNS-1:0];
  assign swtch_db = stable[NumCh-1:NUM_BTNS];

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_press   <= '0;
      btn_release <= '0;
      sw_change   <= '0;
    end else begin
      btn_press   <= rise[NUM_BTNS-1:0];
      btn_release <= fall[NUM_BTNS-1:0];
      sw_change   <= done[NumCh-1:NUM_BTNS];
    end
  end

  rep_state_e     rep_state [NUM_BTNS];
  logic [RcW-1:0] rcnt      [NUM_BTNS];

  // Release or loss of enable wins over a pulse due in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_repeat <= '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
        rep_state[i] <= StIdle;
        rcnt[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTNS; i++) begin
        btn_repeat[i] <= 1'b0;
        unique case (rep_state[i])
          StIdle: begin
            if (rise[i] && repeat_en[i]) begin
              rep_state[i] <= StDelay;
              rcnt[i]      <= '0;
            end
          end
          StDelay: begin
            if (fall[i] || !repeat_en[i]) begin
              rep_state[i] <= StIdle;
              rcnt[i]      <= '0;
            end else if (rcnt[i] == RcW'(REPEAT_DELAY - 1)) begin
              btn_repeat[i] <= 1'b1;
              rep_state[i]  <= StRepeat;
              rcnt[i]       <= '0;
            end else begin
              rcnt[i] <= rcnt[i] + 1'b1;
            end
          end
          StRepeat: begin
            if (fall[i] || !repeat_en[i]) begin
              rep_state[i] <= StIdle;
              rcnt[i]      <= '0;
            end else if (rcnt[i] == RcW'(REPEAT_RATE - 1)) begin
              btn_repeat[i] <= 1'b1;
              rcnt[i]       <= '0;
            end else begin
              rcnt[i] <= rcnt[i] + 1'b1;
            end
          end
          default: begin
            rep_state[i] <= StIdle;
            rcnt[i]      <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised successor to the board-level button/switch debouncer that feeds the bot I/O interface and the CPU reset.
- N-channel button and M-channel switch debouncing with per-pin polarity selection.
- Adds one-cycle press/release/change event pulses and a per-button auto-repeat mode, so firmware can poll events instead of levels.
- Sits between the board pins and the I/O interface / system reset; `pbtn_db[0]` remains the system reset source.

Parameters:
- NUM_BTNS, 6, number of pushbutton channels
- NUM_SW, 16, number of switch channels
- CLK_FREQ_HZ, 100000000, clk frequency
- DB_TIME_US, 5000, required stable time before an output changes
- REPEAT_DELAY_MS, 500, hold time before the first auto-repeat pulse
- REPEAT_RATE_MS, 100, period of subsequent auto-repeat pulses
- BTN_ACTIVE_LOW, 6'b000001, per-button mask; a set bit inverts that pin so `pbtn_db` is always active-high
- SIMULATE, 0, when 1 overrides the time constants: DB_COUNT=4, REPEAT_DELAY=20, REPEAT_RATE=8 cycles

Ports:
- clk, in, 1, system clock
- reset, in, 1, synchronous active-high reset
- pbtn_in, in, NUM_BTNS, raw button pins (asynchronous)
- switch_in, in, NUM_SW, raw switch pins (asynchronous)
- repeat_en, in, NUM_BTNS, per-button auto-repeat enable
- pbtn_db, out, NUM_BTNS, debounced button level (active-high)
- swtch_db, out, NUM_SW, debounced switch level
- btn_press, out, NUM_BTNS, 1-cycle pulse on debounced 0->1
- btn_release, out, NUM_BTNS, 1-cycle pulse on debounced 1->0
- btn_repeat, out, NUM_BTNS, 1-cycle auto-repeat pulse
- sw_change, out, NUM_SW, 1-cycle pulse on any debounced switch transition

Behaviour:
- One clock: clk. Reset is synchronous and active-high on port `reset`. All state changes occur on the rising edge of clk.
- Derived constants:
  - DB_COUNT = CLK_FREQ_HZ/1e6*DB_TIME_US.
  - REPEAT_DELAY and REPEAT_RATE are computed likewise from the millisecond parameters.
  - All are integer cycles, minimum 1.
  - Counter widths are $clog2(constant+1).
- Input conditioning: each channel applies the polarity inversion from BTN_ACTIVE_LOW (buttons only), then a 2-flop synchroniser (sync1, sync2).
- Debounce, per channel (buttons and switches identical):
  - State is `stable` plus `cnt`.
  - If sync2==stable: cnt<=0.
  - Else if cnt==DB_COUNT-1: stable<=sync2, cnt<=0, and the event pulse fires.
  - Else: cnt<=cnt+1.
  - Any return to the stable level before the count completes clears cnt; there is no partial credit.
- Latency: a level held steady appears on the output on the (DB_COUNT+2)th rising edge at which it is sampled, counting the first as 1. With SIMULATE=1 this is the 6th edge.
- Event pulses:
  - btn_press, btn_release and sw_change are registered and asserted for exactly the cycle in which the corresponding pbtn_db/swtch_db first shows the new value.
  - Pulses are never asserted for two consecutive cycles on one channel.
- Auto-repeat, per button, with an idle/delay/repeat FSM:
  - IDLE: on press with repeat_en[i]=1, go to DELAY and load rcnt=0.
  - DELAY: rcnt counts each cycle. At rcnt==REPEAT_DELAY-1, pulse btn_repeat, go to REPEAT and set rcnt=0.
  - REPEAT: at rcnt==REPEAT_RATE-1, pulse btn_repeat and set rcnt=0.
  - The first repeat pulse is REPEAT_DELAY cycles after btn_press; later pulses follow every REPEAT_RATE cycles.
  - Debounced release, or repeat_en[i] deasserting, returns the FSM to IDLE the next cycle with no further pulses.
  - Asserting repeat_en while a button is already held has no effect until the next press.
  - btn_press itself is never counted as a repeat.
- Reset:
  - sync flops, stable, cnt, rcnt and FSMs clear to 0/IDLE.
  - All outputs are 0.
  - A pin that is active during or after reset produces its press/change pulse DB_COUNT+2 cycles after reset deasserts.
  - Reset mid-debounce or mid-repeat aborts the operation with no pulse.
- Simultaneous events: channels are fully independent. Multiple bits of any event vector may pulse in the same cycle.

Test Plan:
- Reset and polarity, SIMULATE=1: hold reset 3 cycles with pbtn_in=6'b000001 and switch_in=0 -> all outputs 0 during reset; afterwards pbtn_db stays 0 (bit 0 inverted) with no pulses for 50 cycles.
- Clean press: drive pbtn_in[1]=1 at edge 0 -> pbtn_db[1]=1 and btn_press[1]=1 for one cycle at edge 6. Release -> btn_release[1] one-cycle pulse 6 edges after the release.
- Bounce rejection: toggle switch_in[3] high 3 cycles, low 1, high 3, low -> swtch_db[3] stays 0 and sw_change is never asserted. Then hold high 4+ cycles -> swtch_db[3] rises on the 6th edge of the hold.
- Auto-repeat: repeat_en[2]=1; press held 60 cycles; btn_press[2] at cycle T -> btn_repeat[2] pulses at T+20, T+28, T+36, T+44, T+52. After release there are no more pulses and btn_release fires.
- Repeat gating: repeat_en[2]=0 while held past T+30 -> no pulse after the last one before deassert. Re-asserting repeat_en while still held -> still no pulses.
- Simultaneous/reset abort: press buttons 1 and 4 on the same edge -> both btn_press bits pulse in the same cycle. Then assert reset at T+25 during repeat -> all outputs 0 next cycle, with no repeat pulse at T+28.
